// File: rtl/grayscale_control_if.sv
// Byte-stream in / gray-pixel out bus between the RGB source, grayscale_control and the Sobel stage.
interface grayscale_control_if #(
  parameter int unsigned PIXEL_WIDTH_OUT = 8
);
  localparam int unsigned BYTE_W = 8;

  logic                       start_i;
  logic                       byte_rdy_i;
  logic [BYTE_W-1:0]          in_byte_i;
  logic [PIXEL_WIDTH_OUT-1:0] out_px_gray_o;
  logic                       px_rdy_o;
  logic                       start_sobel_o;

  // Source side: streams RGB bytes and observes gray pixels.
  modport master (
    output start_i, byte_rdy_i, in_byte_i,
    input  out_px_gray_o, px_rdy_o, start_sobel_o
  );

  // Converter side.
  modport slave (
    input  start_i, byte_rdy_i, in_byte_i,
    output out_px_gray_o, px_rdy_o, start_sobel_o
  );
endinterface

// File: rtl/grayscale_control.sv
// Collects serial R,G,B bytes, emits one registered gray pixel per triple and
// paces the downstream Sobel stage with a one-cycle enable drop per column.
module grayscale_control #(
  parameter int unsigned COL_PX          = 48,
  parameter int unsigned PIXEL_WIDTH_OUT = 8
) (
  input logic               clk_i,
  input logic               nreset_i,
  grayscale_control_if.slave bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned COL_W  = 8;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_PX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_R = 2'd1,
    GET_G = 2'd2,
    GET_B = 2'd3
  } state_t;

  state_t                     state_q;
  logic [BYTE_W-1:0]          r_q;
  logic [BYTE_W-1:0]          g_q;
  logic [BYTE_W-1:0]          b_q;
  logic [COL_W-1:0]           col_q;
  logic [PIXEL_WIDTH_OUT-1:0] gray_q;
  logic                       px_rdy_q;
  logic                       sobel_q;

  logic [BYTE_W-1:0]          b_src;
  logic [ACC_W-1:0]           acc;

  // Luma accumulator; the B byte is taken straight from the bus on its capture edge
  // so the pixel can be registered on that same edge.
  always_comb begin
    b_src = b_q;
    if (state_q == GET_B && bus.byte_rdy_i) begin
      b_src = bus.in_byte_i;
    end
    acc = ACC_W'(77)  * ACC_W'(r_q)
        + ACC_W'(150) * ACC_W'(g_q)
        + ACC_W'(29)  * ACC_W'(b_src);
  end

  // Byte-phase FSM with registered pixel, strobe, column counter and Sobel enable.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q  <= IDLE;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      col_q    <= '0;
      gray_q   <= '0;
      px_rdy_q <= 1'b0;
      sobel_q  <= 1'b0;
    end else begin
      px_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sobel_q <= 1'b0;
          if (bus.start_i) begin
            state_q <= GET_R;
            col_q   <= '0;
            sobel_q <= 1'b1;
          end
        end
        default: begin
          if (!bus.start_i) begin
            // Frame aborted: any partial pixel (including a same-cycle B byte) is dropped.
            state_q <= IDLE;
            sobel_q <= 1'b0;
          end else begin
            // Counter sits at zero right after a wrap, so a pulse seen with col_q==0 closed a column.
            sobel_q <= !(px_rdy_q && col_q == '0);
            if (bus.byte_rdy_i) begin
              case (state_q)
                GET_R: begin
                  r_q     <= bus.in_byte_i;
                  state_q <= GET_G;
                end
                GET_G: begin
                  g_q     <= bus.in_byte_i;
                  state_q <= GET_B;
                end
                GET_B: begin
                  b_q      <= bus.in_byte_i;
                  gray_q   <= PIXEL_WIDTH_OUT'(acc[ACC_W-1:BYTE_W]);
                  px_rdy_q <= 1'b1;
                  col_q    <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
                  state_q  <= GET_R;
                end
                default: state_q <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.out_px_gray_o = gray_q;
  assign bus.px_rdy_o      = px_rdy_q;
  assign bus.start_sobel_o = sobel_q;

endmodule

// File: tb/tb_grayscale_control.sv
// Directed bench for grayscale_control with a cycle-level reference model.
module tb_grayscale_control;

  localparam int unsigned COL_PX = 3;
  localparam int unsigned PW     = 8;

  logic clk_i    = 1'b0;
  logic nreset_i = 1'b0;

  grayscale_control_if #(.PIXEL_WIDTH_OUT(PW)) bus ();

  grayscale_control #(
    .COL_PX         (COL_PX),
    .PIXEL_WIDTH_OUT(PW)
  ) dut (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: frame activity, bytes gathered, pixels emitted in this frame.
  bit m_active  = 1'b0;
  int m_phase   = 0;
  int m_r       = 0;
  int m_g       = 0;
  int m_pix     = 0;
  bit exp_rdy   = 1'b0;
  int exp_gray  = 0;
  bit exp_sobel = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the outputs must be after each clock edge / reset assertion.
  initial forever begin
    @(posedge clk_i or negedge nreset_i);
    if (!nreset_i) begin
      m_active = 1'b0; m_phase = 0; m_r = 0; m_g = 0; m_pix = 0;
      exp_rdy = 1'b0; exp_gray = 0; exp_sobel = 1'b0;
    end else if (!m_active) begin
      exp_rdy   = 1'b0;
      exp_sobel = 1'b0;
      if (bus.start_i) begin
        m_active  = 1'b1;
        m_phase   = 0;
        m_pix     = 0;
        exp_sobel = 1'b1;
      end
    end else if (!bus.start_i) begin
      m_active  = 1'b0;
      exp_rdy   = 1'b0;
      exp_sobel = 1'b0;
    end else begin
      exp_sobel = !(exp_rdy && (m_pix % int'(COL_PX) == 0));
      exp_rdy   = 1'b0;
      if (bus.byte_rdy_i) begin
        case (m_phase)
          0: m_r = int'(bus.in_byte_i);
          1: m_g = int'(bus.in_byte_i);
          default: begin
            exp_gray = (77 * m_r + 150 * m_g + 29 * int'(bus.in_byte_i)) / 256;
            exp_rdy  = 1'b1;
            m_pix++;
          end
        endcase
        m_phase = (m_phase + 1) % 3;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk_i);
    cmp("cyc_px_rdy",      int'(bus.px_rdy_o),      int'(exp_rdy));
    cmp("cyc_start_sobel", int'(bus.start_sobel_o), int'(exp_sobel));
    cmp("cyc_gray",        int'(bus.out_px_gray_o), exp_gray);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Strobe one byte for one cycle; returns just after the edge that sampled it.
  task automatic send_byte(input logic [7:0] b);
    bus.byte_rdy_i = 1'b1;
    bus.in_byte_i  = b;
    tick();
    bus.byte_rdy_i = 1'b0;
  endtask

  // Returns in the cycle where the pixel strobe must be high.
  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    send_byte(r);
    tick();
    send_byte(g);
    tick();
    send_byte(b);
  endtask

  task automatic expect_pixel(input string name, input int gray);
    cmp({name, "_rdy"},   int'(bus.px_rdy_o),      1);
    cmp({name, "_gray"},  int'(bus.out_px_gray_o), gray);
    cmp({name, "_model"}, exp_gray,                gray);
  endtask

  logic [7:0] pr [4] = '{8'd255, 8'd0,   8'd0,   8'd255};
  logic [7:0] pg [4] = '{8'd0,   8'd255, 8'd0,   8'd255};
  logic [7:0] pb [4] = '{8'd0,   8'd0,   8'd255, 8'd255};
  int         pe [4] = '{76, 149, 28, 255};
  int         col_sobel [9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};

  initial begin
    bus.start_i    = 1'b0;
    bus.byte_rdy_i = 1'b0;
    bus.in_byte_i  = 8'd0;
    nreset_i       = 1'b0;
    repeat (3) tick();
    nreset_i = 1'b1;
    tick();
    cmp("reset_rdy",   int'(bus.px_rdy_o),      0);
    cmp("reset_gray",  int'(bus.out_px_gray_o), 0);
    cmp("reset_sobel", int'(bus.start_sobel_o), 0);

    // Strobes while idle must have no effect.
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(i * 40 + 5));
      cmp("idle_rdy",   int'(bus.px_rdy_o),      0);
      cmp("idle_sobel", int'(bus.start_sobel_o), 0);
    end

    // Start frame with a byte in the same cycle; that byte is ignored.
    bus.start_i = 1'b1;
    send_byte(8'd99);
    cmp("start_sobel_hi", int'(bus.start_sobel_o), 1);
    tick();
    send_pixel(8'd100, 8'd100, 8'd100);
    expect_pixel("p100", 100);
    tick();
    for (int i = 0; i < 4; i++) begin
      send_pixel(pr[i], pg[i], pb[i]);
      expect_pixel("primary", pe[i]);
      tick();
    end

    // Abort after R,G then restart with (10,20,30).
    send_byte(8'd1);
    tick();
    send_byte(8'd2);
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    cmp("abort_rdy",   int'(bus.px_rdy_o),      0);
    cmp("abort_sobel", int'(bus.start_sobel_o), 0);
    bus.start_i = 1'b1;
    tick();
    send_pixel(8'd10, 8'd20, 8'd30);
    expect_pixel("restart", 18);
    tick();

    // start_i falling with the B strobe drops the pixel.
    send_byte(8'd200);
    tick();
    send_byte(8'd200);
    tick();
    bus.start_i = 1'b0;
    send_byte(8'd200);
    cmp("drop_b_rdy", int'(bus.px_rdy_o), 0);
    tick();
    cmp("drop_b_rdy2", int'(bus.px_rdy_o), 0);
    bus.start_i = 1'b1;
    tick();

    // Nine pixels in a fresh frame; next R strobe lands in the enable-low cycle.
    for (int k = 0; k < 9; k++) begin
      send_pixel(8'(k * 20 + 3), 8'(k * 10 + 7), 8'(k * 5 + 1));
      cmp("col_pulse",       int'(bus.px_rdy_o),      1);
      cmp("col_sobel_pulse", int'(bus.start_sobel_o), 1);
      tick();
      cmp("col_sobel_after", int'(bus.start_sobel_o), col_sobel[k]);
    end
    tick();

    // Reset mid-pixel after the G strobe.
    send_byte(8'd50);
    tick();
    send_byte(8'd60);
    tick();
    #2 nreset_i = 1'b0;
    #1;
    cmp("midrst_rdy",   int'(bus.px_rdy_o),      0);
    cmp("midrst_gray",  int'(bus.out_px_gray_o), 0);
    cmp("midrst_sobel", int'(bus.start_sobel_o), 0);
    bus.start_i = 1'b0;
    tick();
    nreset_i = 1'b1;
    tick();
    tick();
    cmp("postrst_sobel", int'(bus.start_sobel_o), 0);
    bus.start_i = 1'b1;
    tick();
    send_pixel(8'd255, 8'd0, 8'd0);
    expect_pixel("post_reset", 76);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/grayscale_control.md
GRAYSCALE_CONTROL -- requirements
Module: grayscale_control

Interface
REQ-001 Parameter: COL_PX, default 48, number of gray pixels per image column before the downstream Sobel stage restarts its window.
REQ-002 Parameter: PIXEL_WIDTH_OUT, default 8 (shared parameter header), width of the gray pixel.
REQ-003 Port: clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port: nreset_i, input, 1, asynchronous active-low reset.
REQ-005 Port: start_i, input, 1, frame active; high while RGB bytes are streamed.
REQ-006 Port: byte_rdy_i, input, 1, in_byte_i valid this cycle (single-cycle strobe per byte).
REQ-007 Port: in_byte_i, input, 8, serial colour byte, order R, G, B per pixel.
REQ-008 Port: out_px_gray_o, output, PIXEL_WIDTH_OUT, registered gray pixel to the Sobel stage.
REQ-009 Port: px_rdy_o, output, 1, one-cycle strobe marking out_px_gray_o valid.
REQ-010 Port: start_sobel_o, output, 1, enables the downstream Sobel stage; low for one cycle marks a column restart.

Function
REQ-011 The FSM SHALL have states IDLE, GET_R, GET_G, GET_B.
REQ-012 IDLE -> GET_R when start_i=1; bytes strobed in IDLE SHALL be ignored.
REQ-013 GET_R/GET_G/GET_B: with byte_rdy_i=1, capture in_byte_i into the R/G/B register and advance GET_R->GET_G->GET_B->GET_R; without a strobe, hold state.
REQ-014 start_i=0 in any non-IDLE state -> IDLE next cycle; a partially collected pixel SHALL be discarded and no px_rdy_o issued for it.
REQ-015 start_i falling in the same cycle as the B strobe: start_i wins; the B byte is dropped and no pixel is emitted.
REQ-016 Gray value SHALL be (77*R + 150*G + 29*B) >> 8, using a 16-bit unsigned accumulator; result always within 0..255, no saturation logic.
REQ-017 Latency: px_rdy_o SHALL pulse high exactly one cycle after the clock edge that accepts the B byte, with out_px_gray_o updated on that same edge.
REQ-018 out_px_gray_o SHALL hold its value until the next pixel is emitted; px_rdy_o SHALL never be high two consecutive cycles.
REQ-019 An 8-bit column counter SHALL increment on each emitted pixel and wrap to 0 after reaching COL_PX-1.
REQ-020 start_sobel_o SHALL be registered: high from the cycle after IDLE->GET_R, low in IDLE.
REQ-021 On column wrap, start_sobel_o SHALL be low for exactly the one cycle following the px_rdy_o pulse of pixel COL_PX-1, then return high if start_i is still 1.
REQ-022 R/G/B byte collection SHALL continue during the start_sobel_o low cycle; a byte strobed then is accepted normally.
REQ-023 Leaving IDLE SHALL clear the column counter and the byte phase to R.

Reset
REQ-024 nreset_i=0 SHALL immediately force state IDLE; out_px_gray_o=0, px_rdy_o=0, start_sobel_o=0, column counter=0, R/G/B registers=0.
REQ-025 Reset asserted mid-pixel SHALL discard the partial pixel; after release the block waits in IDLE for start_i.

Verification
REQ-026 start_i=1, strobes R=100,G=100,B=100 -> one px_rdy_o pulse one cycle after B, out_px_gray_o=100.
REQ-027 Pixels (255,0,0), (0,255,0), (0,0,255) -> out_px_gray_o 76, 149, 28 respectively; (255,255,255) -> 255.
REQ-028 COL_PX=3, nine pixels streamed -> start_sobel_o low exactly one cycle after pulses 3, 6, 9; high otherwise.
REQ-029 start_i dropped after R,G strobes, then restarted with (10,20,30) -> no pulse for the aborted pixel; next pulse gives 18.
REQ-030 Byte strobes while start_i=0 -> no state change, px_rdy_o stays 0; nreset_i pulsed after G strobe -> all outputs 0, IDLE.
